toggle_event_decoder: RTL

//   Receiving end of a toggle-signalling link: an upstream T flip-flop flips a level line once per event;

---
 rtl/toggle_event_decoder.sv | 113 +++++++++++
 1 files changed

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//   Receiving end of a toggle-signalling link. An upstream T flip-flop flips
//   tog_in once per event. This block turns each level change back into a
//   one-cycle pulse and counts the events in a saturating pending counter,
//   which a consumer drains one event per valid/ready handshake.
//
//   Build option: define TOG_SYNC_EN to put a 2-flop synchronizer in front of
//   the sample flop. tog_in may then be asynchronous to clk. The latency becomes
//   4 edges and the prime window becomes 3 edges. Without the macro, tog_in must
//   be synchronous to clk, the latency is 2 edges and the prime window is 1 edge.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   tog_in     in   toggle line, every level change is one event
//   evt_pulse  out  one-cycle pulse per detected level change
//   evt_valid  out  high while pend_cnt != 0
//   evt_ready  in   consumer accept (pop when evt_valid && evt_ready)
//   pend_cnt   out  queued, unconsumed events (saturates at 2**CNT_W-1)
//   overflow   out  sticky: event lost because pend_cnt was saturated
//   clr_ovf    in   synchronous clear of overflow (a same-cycle set wins)
module toggle_event_decoder #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  output logic             evt_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow,
  input  logic             clr_ovf
);

  typedef enum logic {PRIME, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state_q, state_d;
  logic [1:0] prime_q, prime_d;
  logic       samp, samp_d, last;
  logic       det, pop;

`ifdef TOG_SYNC_EN
  localparam logic [1:0] PRIME_LAST = 2'd2;
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], tog_in};
  end

  assign samp_d = sync_q[1];
`else
  localparam logic [1:0] PRIME_LAST = 2'd0;
  assign samp_d = tog_in;
`endif

  // Next-state logic. PRIME stays active until the sample path holds the real
  // line level. This stops the level present at reset release from being
  // counted as an event.
  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    case (state_q)
      PRIME: begin
        prime_d = prime_q + 2'd1;
        if (prime_q == PRIME_LAST) begin
          state_d = RUN;
          prime_d = '0;
        end
      end
      RUN: ;
      default: state_d = PRIME;
    endcase
  end

  assign det       = (state_q == RUN) && (samp ^ last);
  assign evt_valid = (pend_cnt != '0);
  assign pop       = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PRIME;
      prime_q   <= '0;
      samp      <= 1'b0;
      last      <= 1'b0;
      evt_pulse <= 1'b0;
      pend_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prime_q   <= prime_d;
      samp      <= samp_d;
      // In PRIME, the baseline is the level that samp loads on this same edge.
      // samp itself still holds its reset value.
      last      <= (state_q == PRIME) ? samp_d : samp;
      evt_pulse <= det;

      if (det && !pop) begin
        if (pend_cnt == CNT_MAX) overflow <= 1'b1;
        else                     pend_cnt <= pend_cnt + 1'b1;
      end else if (!det && pop) begin
        pend_cnt <= pend_cnt - 1'b1;
      end

      // A set in the saturation branch above takes priority over the clear.
      if (clr_ovf && !(det && !pop && pend_cnt == CNT_MAX)) overflow <= 1'b0;
    end
  end

endmodule
